// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencer for an R-type RISC-V datapath (add/sub/and/or).
// Each instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK, taking 4 cycles when imem acks with no wait.
// imem_ack stalls FETCH, and a bounded wait traps; trap_clr is the only way out of TRAP.
module rv_multicycle_ctrl #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  input  logic             trap_clr,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_en,
  output logic             rf_we,
  output logic [1:0]       alu_control,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retire_cnt
);

  // The wait counter must reach FETCH_TIMEOUT without overflowing.
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] fetch_cnt;
  logic          fetch_expire;
  logic          dec_legal;
  logic [1:0]    dec_alu;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rd;
  logic          unused_rs;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // The controller never looks at the source register fields.
  assign unused_rs = ^instr[24:15];

  // The last allowed FETCH cycle has arrived and there is still no ack.
  // An ack in that same cycle takes priority over the timeout.
  assign fetch_expire = (state == S_FETCH) && !imem_ack && (fetch_cnt == TO_LAST);

  // Decode the R-type op: opcode OP plus one of the four supported funct pairs.
  always_comb begin
    dec_legal = 1'b0;
    dec_alu   = 2'b00;
    if (opcode == 7'b0110011) begin
      case ({funct7, funct3})
        10'b0000000_000: begin dec_legal = 1'b1; dec_alu = 2'b00; end
        10'b0100000_000: begin dec_legal = 1'b1; dec_alu = 2'b01; end
        10'b0000000_111: begin dec_legal = 1'b1; dec_alu = 2'b10; end
        10'b0000000_110: begin dec_legal = 1'b1; dec_alu = 2'b11; end
        default:         begin dec_legal = 1'b0; dec_alu = 2'b00; end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic and the strobes decoded from the current state.
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_en    = 1'b0;
    rf_we    = 1'b0;
    busy     = 1'b1;
    trap     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (en) state_n = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_n = S_DECODE;
        end else if (fetch_expire) begin
          state_n = S_TRAP;
        end
      end
      S_DECODE: begin
        state_n = dec_legal ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        state_n = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_en   = 1'b1;
        rf_we   = (rd != 5'd0);
        state_n = en ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        busy = 1'b0;
        trap = 1'b1;
        if (trap_clr) state_n = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Count consecutive ack-less FETCH cycles; any other cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 fetch_cnt <= '0;
    else if (state == S_FETCH && !imem_ack)  fetch_cnt <= fetch_cnt + TW'(1);
    else                                     fetch_cnt <= '0;
  end

  // Capture the ALU op at the end of DECODE, hold it through WRITEBACK, and clear it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_control <= 2'b00;
    end else begin
      case (state)
        S_DECODE:  alu_control <= dec_legal ? dec_alu : 2'b00;
        S_EXECUTE: alu_control <= alu_control;
        default:   alu_control <= 2'b00;
      endcase
    end
  end

  // Latch the trap cause when entering TRAP; clear it when trap_clr releases the trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                trap_cause <= CAUSE_NONE;
    else if (fetch_expire)                  trap_cause <= CAUSE_TIMEOUT;
    else if (state == S_DECODE && !dec_legal) trap_cause <= CAUSE_ILLEGAL;
    else if (state == S_TRAP && trap_clr)   trap_cause <= CAUSE_NONE;
  end

  // Count retired instructions; each WRITEBACK cycle retires one, and the count wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         retire_cnt <= '0;
    else if (state == S_WRITEBACK)   retire_cnt <= retire_cnt + CNT_W'(1);
  end

endmodule
